// File: rtl/spi_cmd_ctrl.sv
// spi_cmd_ctrl
// Turns the byte stream of each SPI slave-select frame into single-cycle
// register-file strobes. The first byte of a frame is a command
// (bit7 = 1 write / 0 read, bits6:0 = start address). Every following byte
// produces one write or read access.
//
// Optional feature macro: SPI_CMD_AUTO_INC_EN
//   defined   - the address advances after every data byte (bursts).
//   undefined - one access per frame; later bytes are drained.
//
// Ports
//   i_sys_clk     system clock, rising edge
//   i_sys_rst     synchronous active-high reset
//   i_spi_ss      slave select (synchronised), 0 = frame active
//   i_byte        received byte
//   i_byte_valid  one-cycle strobe qualifying i_byte
//   o_reg_addr    register address of the current access
//   o_reg_wdata   write data
//   o_reg_we      one-cycle write strobe
//   o_reg_re      one-cycle read strobe
//   o_busy        high while a frame is being tracked
//   o_byte_count  data bytes accepted in the current/last frame (saturating)
//   o_frame_err   one-cycle pulse when a frame ends without data
module spi_cmd_ctrl (
   input  logic       i_sys_clk,
   input  logic       i_sys_rst,
   input  logic       i_spi_ss,
   input  logic [7:0] i_byte,
   input  logic       i_byte_valid,
   output logic [6:0] o_reg_addr,
   output logic [7:0] o_reg_wdata,
   output logic       o_reg_we,
   output logic       o_reg_re,
   output logic       o_busy,
   output logic [7:0] o_byte_count,
   output logic       o_frame_err
);

   typedef enum logic [2:0] {
      ST_SYNC  = 3'd0,
      ST_IDLE  = 3'd1,
      ST_CMD   = 3'd2,
      ST_DATA  = 3'd3,
      ST_DRAIN = 3'd4
   } state_t;

   state_t     state_q, state_d;
   logic [6:0] reg_addr_q, reg_addr_d;
   logic [7:0] reg_wdata_q, reg_wdata_d;
   logic       reg_we_q, reg_we_d;
   logic       reg_re_q, reg_re_d;
   logic [7:0] byte_count_q, byte_count_d;
   logic       frame_err_q, frame_err_d;
   logic       rw_q, rw_d;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // State register
   always_ff @(posedge i_sys_clk) begin
      if (i_sys_rst) begin
         state_q <= ST_SYNC;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic. A byte arriving together with ss high is processed
   // first; the frame still closes on the same edge.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_SYNC:  if (i_spi_ss) state_d = ST_IDLE;
         ST_IDLE:  if (!i_spi_ss) state_d = ST_CMD;
         ST_CMD: begin
            if (i_spi_ss)          state_d = ST_IDLE;
            else if (i_byte_valid) state_d = ST_DATA;
         end
         ST_DATA: begin
            if (i_spi_ss) begin
               state_d = ST_IDLE;
            end else if (i_byte_valid) begin
`ifdef SPI_CMD_AUTO_INC_EN
               state_d = ST_DATA;
`else
               state_d = ST_DRAIN;
`endif
            end
         end
         ST_DRAIN: if (i_spi_ss) state_d = ST_IDLE;
         default:  state_d = ST_SYNC;
      endcase
   end

   // Output / datapath next values
   always_comb begin
      reg_addr_d   = reg_addr_q;
      reg_wdata_d  = reg_wdata_q;
      reg_we_d     = 1'b0;
      reg_re_d     = 1'b0;
      byte_count_d = byte_count_q;
      frame_err_d  = 1'b0;
      rw_d         = rw_q;
      o_busy       = (state_q == ST_CMD) || (state_q == ST_DATA) ||
                     (state_q == ST_DRAIN);

`ifdef SPI_CMD_AUTO_INC_EN
      // Advance one cycle after the strobe so the address stays stable
      // while the access is presented; 7-bit wrap is intentional.
      if (reg_we_q || reg_re_q) reg_addr_d = reg_addr_q + 7'd1;
`endif

      case (state_q)
         ST_IDLE: begin
            if (!i_spi_ss) byte_count_d = 8'd0;
         end
         ST_CMD: begin
            if (i_byte_valid) begin
               rw_d       = i_byte[7];
               reg_addr_d = i_byte[6:0];
            end
            // Leaving CMD always means the frame carried no data byte.
            if (i_spi_ss) frame_err_d = 1'b1;
         end
         ST_DATA: begin
            if (i_byte_valid) begin
               if (rw_q) begin
                  reg_we_d    = 1'b1;
                  reg_wdata_d = i_byte;
               end else begin
                  reg_re_d = 1'b1;
               end
               byte_count_d = sat_inc(byte_count_q);
            end
            if (i_spi_ss && (byte_count_d == 8'd0)) frame_err_d = 1'b1;
         end
         default: ;
      endcase
   end

   // Registered outputs
   always_ff @(posedge i_sys_clk) begin
      if (i_sys_rst) begin
         reg_addr_q   <= 7'd0;
         reg_wdata_q  <= 8'd0;
         reg_we_q     <= 1'b0;
         reg_re_q     <= 1'b0;
         byte_count_q <= 8'd0;
         frame_err_q  <= 1'b0;
         rw_q         <= 1'b0;
      end else begin
         reg_addr_q   <= reg_addr_d;
         reg_wdata_q  <= reg_wdata_d;
         reg_we_q     <= reg_we_d;
         reg_re_q     <= reg_re_d;
         byte_count_q <= byte_count_d;
         frame_err_q  <= frame_err_d;
         rw_q         <= rw_d;
      end
   end

   assign o_reg_addr   = reg_addr_q;
   assign o_reg_wdata  = reg_wdata_q;
   assign o_reg_we     = reg_we_q;
   assign o_reg_re     = reg_re_q;
   assign o_byte_count = byte_count_q;
   assign o_frame_err  = frame_err_q;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Self-checking bench for spi_cmd_ctrl: a frame-level model predicts every
// output each cycle; directed frames additionally pin literal results.
module tb_spi_cmd_ctrl;

`ifdef SPI_CMD_AUTO_INC_EN
   localparam bit AUTO         = 1'b1;
   localparam int EXP_BURST_RE = 3;
   localparam int EXP_BURST_CNT = 3;
   localparam int EXP_LONG_WE  = 256;
   localparam int EXP_LONG_CNT = 255;
   localparam int EXP_LONG_ADDR = 8'h7F;
`else
   localparam bit AUTO         = 1'b0;
   localparam int EXP_BURST_RE = 1;
   localparam int EXP_BURST_CNT = 1;
   localparam int EXP_LONG_WE  = 1;
   localparam int EXP_LONG_CNT = 1;
   localparam int EXP_LONG_ADDR = 0;
`endif

   logic       clk = 1'b0;
   logic       i_sys_rst, i_spi_ss, i_byte_valid;
   logic [7:0] i_byte;
   logic [6:0] o_reg_addr;
   logic [7:0] o_reg_wdata, o_byte_count;
   logic       o_reg_we, o_reg_re, o_busy, o_frame_err;

   spi_cmd_ctrl dut (
      .i_sys_clk   (clk),
      .i_sys_rst   (i_sys_rst),
      .i_spi_ss    (i_spi_ss),
      .i_byte      (i_byte),
      .i_byte_valid(i_byte_valid),
      .o_reg_addr  (o_reg_addr),
      .o_reg_wdata (o_reg_wdata),
      .o_reg_we    (o_reg_we),
      .o_reg_re    (o_reg_re),
      .o_busy      (o_busy),
      .o_byte_count(o_byte_count),
      .o_frame_err (o_frame_err)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // Frame-level model
   bit         m_ok = 0;
   bit         m_synced, m_in, m_cmd, m_drained, m_rw;
   logic [6:0] m_start;
   int         m_acc, m_cnt;
   logic [7:0] m_wdata;
   bit         e_we, e_re, e_err, e_busy;
   logic [6:0] e_addr;

   // Observed activity, for literal checks
   int         we_log = 0, re_log = 0, err_log = 0;
   logic [6:0] alog[$];
   logic [7:0] dlog[$];
   int         b_we, b_re, b_err, b_q;
   logic [7:0] dbuf[0:255];

   task automatic model_step();
      e_we = 0; e_re = 0; e_err = 0;
      if (i_sys_rst) begin
         m_ok = 1; m_synced = 0; m_in = 0; m_cmd = 0; m_drained = 0; m_rw = 0;
         m_start = 0; m_acc = 0; m_cnt = 0; m_wdata = 0;
      end else if (!m_synced) begin
         m_synced = i_spi_ss;
      end else if (!m_in) begin
         if (!i_spi_ss) begin
            m_in = 1; m_cmd = 0; m_drained = 0; m_cnt = 0;
         end
      end else begin
         if (i_byte_valid) begin
            if (!m_cmd) begin
               m_cmd = 1; m_rw = i_byte[7]; m_start = i_byte[6:0]; m_acc = 0;
            end else if (!m_drained) begin
               if (m_rw) begin
                  e_we = 1; m_wdata = i_byte;
               end else begin
                  e_re = 1;
               end
               m_acc++;
               m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
               if (!AUTO) m_drained = 1;
            end
         end
         if (i_spi_ss) begin
            if (!m_drained && m_cnt == 0) e_err = 1;
            m_in = 0;
         end
      end
      e_busy = m_in;
      if (AUTO) e_addr = 7'((int'(m_start) + m_acc - ((e_we || e_re) ? 1 : 0)) % 128);
      else      e_addr = m_start;
   endtask

   task automatic compare_step();
      cyc++;
      if (m_ok) begin
         n_tests++;
         if (o_reg_we !== e_we || o_reg_re !== e_re || o_reg_addr !== e_addr ||
             o_reg_wdata !== m_wdata || o_busy !== e_busy ||
             o_byte_count !== 8'(m_cnt) || o_frame_err !== e_err) begin
            n_fail++;
            $display("FAIL cycle %0d outputs: got we=%b re=%b addr=%h wd=%h busy=%b cnt=%0d err=%b, want we=%b re=%b addr=%h wd=%h busy=%b cnt=%0d err=%b",
                     cyc, o_reg_we, o_reg_re, o_reg_addr, o_reg_wdata, o_busy, o_byte_count, o_frame_err,
                     e_we, e_re, e_addr, m_wdata, e_busy, m_cnt, e_err);
         end
         if (o_reg_we === 1'b1) begin we_log++; alog.push_back(o_reg_addr); dlog.push_back(o_reg_wdata); end
         if (o_reg_re === 1'b1) begin re_log++; alog.push_back(o_reg_addr); dlog.push_back(o_reg_wdata); end
         if (o_frame_err === 1'b1) err_log++;
      end
   endtask

   task automatic chk(input string name, input int got, input int want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, got, got, want, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      i_byte = b; i_byte_valid = 1'b1;
      tick();
      i_byte_valid = 1'b0; i_byte = 8'($urandom);
   endtask

   task automatic snap();
      b_we = we_log; b_re = re_log; b_err = err_log; b_q = alog.size();
   endtask

   task automatic frame(input logic [7:0] cmd, input int n, input bit gaps);
      i_spi_ss = 1'b0; tick(); tick();
      send_byte(cmd);
      for (int i = 0; i < n; i++) begin
         send_byte(dbuf[i]);
         if (gaps) repeat ($urandom_range(0, 2)) tick();
      end
      i_spi_ss = 1'b1; tick(); tick(); tick();
   endtask

   initial begin
      i_sys_rst = 1'b1; i_spi_ss = 1'b0; i_byte_valid = 1'b0; i_byte = 8'h00;
      fork
         forever begin @(posedge clk); model_step(); end
         forever begin @(negedge clk); compare_step(); end
      join_none

      // Reset state, then bytes while ss was never high are ignored
      repeat (3) tick();
      chk("reset addr", int'(o_reg_addr), 0);
      chk("reset wdata/we/re", int'({o_reg_wdata, o_reg_we, o_reg_re}), 0);
      chk("reset busy/cnt/err", int'({o_busy, o_byte_count, o_frame_err}), 0);
      i_sys_rst = 1'b0;
      snap();
      send_byte(8'h85); send_byte(8'h3C); tick();
      chk("sync ignores bytes", we_log - b_we, 0);
      chk("sync busy", int'(o_busy), 0);
      i_spi_ss = 1'b1; tick(); tick();

      // Write frame
      snap(); dbuf[0] = 8'h3C;
      frame(8'h85, 1, 1'b0);
      chk("write we count", we_log - b_we, 1);
      chk("write addr", int'(alog[b_q]), 8'h05);
      chk("write wdata", int'(dlog[b_q]), 8'h3C);
      chk("write byte_count", int'(o_byte_count), 1);
      chk("write no err", err_log - b_err, 0);

      // Read burst across the address wrap
      snap(); dbuf[0] = 0; dbuf[1] = 0; dbuf[2] = 0;
      frame(8'h7E, 3, 1'b1);
      chk("burst re count", re_log - b_re, EXP_BURST_RE);
      chk("burst addr0", int'(alog[b_q]), 8'h7E);
`ifdef SPI_CMD_AUTO_INC_EN
      chk("burst addr1", int'(alog[b_q+1]), 8'h7F);
      chk("burst addr2", int'(alog[b_q+2]), 8'h00);
`endif
      chk("burst byte_count", int'(o_byte_count), EXP_BURST_CNT);

      // Command without data, then a frame without any byte
      snap();
      frame(8'h81, 0, 1'b0);
      chk("empty no strobe", (we_log - b_we) + (re_log - b_re), 0);
      chk("empty err", err_log - b_err, 1);
      snap();
      i_spi_ss = 1'b0; tick(); tick(); i_spi_ss = 1'b1; tick(); tick(); tick();
      chk("bare ss err", err_log - b_err, 1);

      // Data byte coincident with ss rising
      snap();
      i_spi_ss = 1'b0; tick(); tick();
      send_byte(8'h90); tick();
      i_byte = 8'hA5; i_byte_valid = 1'b1; i_spi_ss = 1'b1; tick();
      i_byte_valid = 1'b0; tick(); tick();
      chk("simul we count", we_log - b_we, 1);
      chk("simul addr", int'(alog[b_q]), 8'h10);
      chk("simul wdata", int'(dlog[b_q]), 8'hA5);
      chk("simul no err", err_log - b_err, 0);
      chk("simul idle", int'(o_busy), 0);

      // Reset mid-frame with ss held low; reset wins over a coincident byte
      snap();
      i_spi_ss = 1'b0; tick(); tick();
      send_byte(8'h82);
      i_byte = 8'h33; i_byte_valid = 1'b1; i_sys_rst = 1'b1; tick();
      i_sys_rst = 1'b0; i_byte_valid = 1'b0;
      send_byte(8'h80); send_byte(8'h44); tick();
      chk("rst mid no strobe", we_log - b_we, 0);
      chk("rst mid busy", int'(o_busy), 0);
      i_spi_ss = 1'b1; tick(); tick();
      snap(); dbuf[0] = 8'h11;
      frame(8'h80, 1, 1'b0);
      chk("after rst addr", int'(alog[b_q]), 8'h00);
      chk("after rst wdata", int'(dlog[b_q]), 8'h11);

      // 256 back-to-back data bytes
      snap();
      for (int i = 0; i < 256; i++) dbuf[i] = 8'(i * 7 + 3);
      frame(8'h80, 256, 1'b0);
      chk("long we count", we_log - b_we, EXP_LONG_WE);
      chk("long byte_count", int'(o_byte_count), EXP_LONG_CNT);
      chk("long last addr", int'(alog[alog.size()-1]), EXP_LONG_ADDR);

      // Randomised traffic with occasional resets
      for (int c = 0; c < 4000; c++) begin
         i_sys_rst = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 9) == 0) i_spi_ss = ~i_spi_ss;
         i_byte_valid = 1'($urandom_range(0, 1));
         i_byte = 8'($urandom);
         tick();
      end
      i_sys_rst = 1'b0; i_byte_valid = 1'b0;
      repeat (3) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
